// File: rtl/counter_b4_seq.sv
// Command sequencer for the 4-bit counter: FIFO-buffered commands drive the counter's
// enable/mode/D/reset inputs for a programmed number of cycles, with early stop on rco.
module counter_b4_seq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic                       b4_clk,
  input  logic                       b4_reset,
  input  logic                       flush,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_mode,
  input  logic [3:0]                 cmd_data,
  input  logic [LEN_W-1:0]           cmd_len,
  input  logic                       cmd_stop,
  input  logic                       rco_in,
  output logic                       ctr_enable,
  output logic [1:0]                 ctr_mode,
  output logic [3:0]                 ctr_D,
  output logic                       ctr_reset,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = $clog2(DEPTH + 1);
  localparam int unsigned ENTRY_W = 2 + 4 + LEN_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                stop_q, stop_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    level_d;
  logic                enable_d;
  logic [1:0]          mode_d;
  logic [3:0]          data_d;
  logic                done_d;
  logic                busy_d;
  logic                push;
  logic                pop;
  logic [ENTRY_W-1:0]  mem [DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [1:0]          head_mode;
  logic [3:0]          head_data;
  logic [LEN_W-1:0]    head_len;
  logic                head_stop;

  // No bypass: a full FIFO refuses even in a popping cycle.
  assign cmd_ready = (level < LVL_W'(DEPTH)) && !flush && !b4_reset;
  assign push      = cmd_valid && cmd_ready;

  assign head      = mem[rd_ptr_q];
  assign head_mode = head[ENTRY_W-1 -: 2];
  assign head_data = head[LEN_W+1 +: 4];
  assign head_len  = head[1 +: LEN_W];
  assign head_stop = head[0];

  // Next-state, FIFO bookkeeping and counter drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stop_d   = stop_q;
    enable_d = ctr_enable;
    mode_d   = ctr_mode;
    data_d   = ctr_D;
    done_d   = 1'b0;
    pop      = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level;

    case (state_q)
      IDLE: begin
        enable_d = 1'b0;
        if (level != '0) begin
          pop      = 1'b1;
          cnt_d    = (head_mode == 2'b11) ? '0 : head_len;
          stop_d   = head_stop;
          enable_d = 1'b1;
          mode_d   = head_mode;
          data_d   = head_data;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (cnt_q == '0 || (stop_q && rco_in)) begin
          enable_d = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   level_d = level + LVL_W'(1);
      2'b01:   level_d = level - LVL_W'(1);
      default: level_d = level;
    endcase

    // Reset and flush abort everything; only reset also clears mode/D.
    if (b4_reset || flush) begin
      state_d  = IDLE;
      enable_d = 1'b0;
      done_d   = 1'b0;
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (b4_reset) begin
        cnt_d  = '0;
        stop_d = 1'b0;
        mode_d = 2'b00;
        data_d = 4'h0;
      end
    end

    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge b4_clk) begin
    state_q    <= state_d;
    cnt_q      <= cnt_d;
    stop_q     <= stop_d;
    wr_ptr_q   <= wr_ptr_d;
    rd_ptr_q   <= rd_ptr_d;
    level      <= level_d;
    ctr_enable <= enable_d;
    ctr_mode   <= mode_d;
    ctr_D      <= data_d;
    done       <= done_d;
    busy       <= busy_d;
    ctr_reset  <= b4_reset || flush;
  end

  // Storage needs no reset: pointers and level define which entries are valid.
  always_ff @(posedge b4_clk) begin
    if (push) mem[wr_ptr_q] <= {cmd_mode, cmd_data, cmd_len, cmd_stop};
  end

endmodule

// File: tb/tb_counter_b4_seq.sv
// Self-checking bench for counter_b4_seq: table of single commands plus
// hand-written sequences for FIFO fill, flush and mid-command reset.
module tb_counter_b4_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LEN_W = 4;

  logic       b4_clk = 1'b0;
  logic       b4_reset = 1'b1;
  logic       flush = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic [3:0] cmd_data = 4'h0;
  logic [3:0] cmd_len = 4'h0;
  logic       cmd_stop = 1'b0;
  logic       rco_in = 1'b0;
  logic       ctr_enable;
  logic [1:0] ctr_mode;
  logic [3:0] ctr_D;
  logic       ctr_reset;
  logic       busy;
  logic       done;
  logic [2:0] level;

  counter_b4_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .b4_clk(b4_clk), .b4_reset(b4_reset), .flush(flush),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_data(cmd_data), .cmd_len(cmd_len), .cmd_stop(cmd_stop),
    .rco_in(rco_in), .ctr_enable(ctr_enable), .ctr_mode(ctr_mode),
    .ctr_D(ctr_D), .ctr_reset(ctr_reset), .busy(busy), .done(done),
    .level(level)
  );

  always #5 b4_clk = ~b4_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_accept = 0;

  always @(posedge b4_clk) cyc <= cyc + 1;

  // Record ctr_mode at every rising edge of ctr_enable to check command order.
  logic [1:0] mode_log [$];
  logic prev_en = 1'b0;
  always @(negedge b4_clk) begin
    if (ctr_enable === 1'b1 && !prev_en) mode_log.push_back(ctr_mode);
    prev_en = (ctr_enable === 1'b1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a command at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [1:0] m, input logic [3:0] d, input logic [3:0] l,
                      input logic s);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_data  = d;
    cmd_len   = l;
    cmd_stop  = s;
    while (!cmd_ready && n < 100) begin
      @(negedge b4_clk);
      n++;
    end
    if (!cmd_ready) begin
      check("push_timeout", int'(cmd_ready), 1);
    end else begin
      @(negedge b4_clk);
      last_accept = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [3:0] data;
    logic [3:0] len;
    logic       stop;
    int         rco_at;      // enable cycle (1-based) during which rco_in is high; 0 = never
    int         exp_cycles;  // expected number of ctr_enable cycles
  } vec_t;

  vec_t vecs [7];
  logic [1:0] exp_order [6];

  initial begin
    int n;
    bit stable;
    bit done_seen;
    int t_a;

    vecs[0] = '{2'b00, 4'h0, 4'd5,  1'b0, 0, 6};
    vecs[1] = '{2'b11, 4'hA, 4'd7,  1'b0, 0, 1};
    vecs[2] = '{2'b00, 4'h3, 4'd15, 1'b1, 4, 4};
    vecs[3] = '{2'b01, 4'h5, 4'd15, 1'b0, 0, 16};
    vecs[4] = '{2'b10, 4'hC, 4'd0,  1'b0, 0, 1};
    vecs[5] = '{2'b00, 4'h6, 4'd3,  1'b0, 2, 4};
    vecs[6] = '{2'b01, 4'h9, 4'd2,  1'b1, 3, 3};
    exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b00;
    exp_order[3] = 2'b11; exp_order[4] = 2'b01; exp_order[5] = 2'b10;

    // Reset for three cycles
    repeat (3) @(negedge b4_clk);
    check("rst_ctr_reset", int'(ctr_reset), 1);
    check("rst_enable", int'(ctr_enable), 0);
    check("rst_level", int'(level), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready", int'(cmd_ready), 0);
    b4_reset = 1'b0;
    @(negedge b4_clk);
    check("rel_ctr_reset", int'(ctr_reset), 0);
    check("rel_ready", int'(cmd_ready), 1);
    check("rel_mode", int'(ctr_mode), 0);
    check("rel_D", int'(ctr_D), 0);

    // Table of single commands
    foreach (vecs[i]) begin
      push(vecs[i].mode, vecs[i].data, vecs[i].len, vecs[i].stop);
      check($sformatf("v%0d_pre_enable", i), int'(ctr_enable), 0);
      @(negedge b4_clk);
      n = 0;
      stable = 1'b1;
      done_seen = 1'b0;
      while (ctr_enable && n < 40) begin
        n++;
        if (ctr_mode != vecs[i].mode || ctr_D != vecs[i].data) stable = 1'b0;
        if (done) done_seen = 1'b1;
        rco_in = (n == vecs[i].rco_at);
        @(negedge b4_clk);
      end
      rco_in = 1'b0;
      check($sformatf("v%0d_cycles", i), n, vecs[i].exp_cycles);
      check($sformatf("v%0d_mode_d_stable", i), int'(stable), 1);
      check($sformatf("v%0d_done_early", i), int'(done_seen), 0);
      check($sformatf("v%0d_done", i), int'(done), 1);
      @(negedge b4_clk);
      check($sformatf("v%0d_done_clear", i), int'(done), 0);
      check($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      check($sformatf("v%0d_mode_hold", i), int'(ctr_mode), int'(vecs[i].mode));
    end

    // FIFO fill: long command, four queued behind it, sixth waits for a pop
    mode_log.delete();
    push(2'b01, 4'h1, 4'd15, 1'b0);
    t_a = last_accept;
    push(2'b10, 4'h2, 4'd1, 1'b0);
    push(2'b00, 4'h3, 4'd0, 1'b0);
    push(2'b11, 4'h4, 4'd5, 1'b0);
    push(2'b01, 4'h5, 4'd2, 1'b0);
    check("fill_level", int'(level), 4);
    check("fill_ready", int'(cmd_ready), 0);
    check("fill_enable", int'(ctr_enable), 1);
    push(2'b10, 4'h6, 4'd0, 1'b0);
    check("sixth_accept_edge", last_accept - t_a, 20);
    n = 0;
    while (busy && n < 200) begin
      @(negedge b4_clk);
      n++;
    end
    check("drain_busy", int'(busy), 0);
    check("order_count", mode_log.size(), 6);
    for (int i = 0; i < 6 && i < mode_log.size(); i++)
      check($sformatf("order_%0d", i), int'(mode_log[i]), int'(exp_order[i]));

    // Flush while running with two commands queued; push in the flush cycle is dropped
    push(2'b00, 4'h7, 4'd15, 1'b0);
    push(2'b01, 4'h8, 4'd3, 1'b0);
    push(2'b10, 4'h9, 4'd3, 1'b0);
    check("pre_flush_level", int'(level), 2);
    check("pre_flush_enable", int'(ctr_enable), 1);
    flush = 1'b1;
    cmd_valid = 1'b1;
    cmd_mode = 2'b11;
    #1;
    check("flush_ready", int'(cmd_ready), 0);
    @(negedge b4_clk);
    flush = 1'b0;
    cmd_valid = 1'b0;
    check("flush_enable", int'(ctr_enable), 0);
    check("flush_ctr_reset", int'(ctr_reset), 1);
    check("flush_level", int'(level), 0);
    check("flush_busy", int'(busy), 0);
    check("flush_done", int'(done), 0);
    @(negedge b4_clk);
    check("flush_ctr_reset_clear", int'(ctr_reset), 0);
    check("flush_done_after", int'(done), 0);
    repeat (3) @(negedge b4_clk);
    check("flush_stays_idle", int'(ctr_enable), 0);
    check("flush_level_after", int'(level), 0);

    // Reset in the middle of a command
    push(2'b01, 4'h5, 4'd15, 1'b0);
    repeat (3) @(negedge b4_clk);
    check("mid_enable", int'(ctr_enable), 1);
    b4_reset = 1'b1;
    @(negedge b4_clk);
    check("mid_rst_ctr_reset", int'(ctr_reset), 1);
    check("mid_rst_enable", int'(ctr_enable), 0);
    @(negedge b4_clk);
    check("mid_rst_hold", int'(ctr_reset), 1);
    check("mid_rst_mode", int'(ctr_mode), 0);
    check("mid_rst_D", int'(ctr_D), 0);
    check("mid_rst_done", int'(done), 0);
    b4_reset = 1'b0;
    @(negedge b4_clk);
    check("mid_rel_ctr_reset", int'(ctr_reset), 0);
    check("mid_rel_busy", int'(busy), 0);
    check("mid_rel_ready", int'(cmd_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
